spi_axi_arbiter: RTL and testbench
==================================

// Module: spi_axi_arbiter
// PURPOSE
//  Round-robin arbiter sharing one AXI4-lite slave port (the spi_axi_slave SPI bridge) among M requesters.
//  Exactly one transaction (write AW+W+B or read AR+R) is outstanding at a time; grant locks until its response.
//  Sits between the core/debug masters and spi_axi_slave; serializes SPI frames so words never interleave.
// PARAMETERS
//  M      2   number of requesters (1..8)
//  sword  32  AXI address/data width
// PORTS (req_* buses flattened: requester i occupies slice [i*W +: W])
//  CLK               in   1        clock, all logic on rising edge
//  RST               in   1        asynchronous active-low reset
//  req_axi_awvalid   in   M        write-address valid per requester
//  req_axi_awready   out  M        write-address ready per requester
//  req_axi_awaddr    in   M*sword  write addresses
//  req_axi_awprot    in   M*3      write protection
//  req_axi_wvalid    in   M        write-data valid
//  req_axi_wready    out  M        write-data ready
//  req_axi_wdata     in   M*sword  write data
//  req_axi_wstrb     in   M*4      write strobes
//  req_axi_bvalid    out  M        write-response valid
//  req_axi_bready    in   M        write-response ready
//  req_axi_arvalid   in   M        read-address valid
//  req_axi_arready   out  M        read-address ready
//  req_axi_araddr    in   M*sword  read addresses
//  req_axi_arprot    in   M*3      read protection
//  req_axi_rvalid    out  M        read-data valid
//  req_axi_rready    in   M        read-data ready
//  req_axi_rdata     out  M*sword  read data (only granted slice valid; others 0)
//  axi_aw*/w*/b*/ar*/r*  out/in   per AXI4-lite, single port to spi_axi_slave
//                        (valids/addr/data/prot/strb/readies driven out; readies/bvalid/rvalid/rdata in)
// BEHAVIOUR
//  - FSM: IDLE, WR, RD. State, grant index g and round-robin pointer p are registered.
//  - Reset (RST=0, async): state=IDLE, g=0, p=0, aw_done=w_done=0.
//    All outputs 0 while in reset and in IDLE.
//  - IDLE: request r[i] = awvalid[i] | arvalid[i]. Pick first i with r[i] searching p, p+1, ... mod M.
//    If awvalid[i], next=WR, else next=RD. Registered: g=i.
//    No request: stay IDLE.
//  - Latency: requester valid in cycle n -> forwarded axi_*valid in cycle n+1 (combinational mux from g).
//  - WR: axi_awvalid = req_awvalid[g] & ~aw_done; axi_wvalid = req_wvalid[g] & ~w_done.
//    Addr/prot/data/strb muxed from slice g.
//    Readies routed back to requester g only; all other requesters see readies/valids 0.
//    aw_done sets on AW handshake; w_done sets on W handshake. AW and W may complete in either order or the same cycle.
//    bvalid/bready pass through between slave and g.
//    On B handshake (axi_bvalid & req_bready[g]): clear done flags, p = (g+1) mod M, next=IDLE.
//  - RD: axi_arvalid = req_arvalid[g] & ~aw_done (aw_done reused as addr-done flag).
//    rvalid/rready/rdata pass through.
//    On R handshake: clear flag, p = (g+1) mod M, next=IDLE.
//  - Requester with both awvalid and arvalid: write served first; read competes on a later arbitration.
//  - A requester dropping valid before handshake (protocol violation) leaves the lock held.
//    No timeout; the requester must complete.
//  - One idle cycle (IDLE) between consecutive transactions; throughput is limited by the SPI frame anyway.
//  - Reset mid-transaction aborts it: outputs drop to 0 immediately and p returns to 0.
//    The slave shares RST.
//  - M=1 degenerates to a pass-through with a one-cycle IDLE gap.
// TESTING
//  1. Reset: hold RST=0 with all req valids=1 -> every output 0. Release -> requester 0 granted, axi_awvalid=1 one cycle later.
//  2. Single write: req0 writes 0xDEADBEEF -> SPI captures 32'hDEADBEEF, req_bvalid[0]=1, req_bvalid[1]=0 throughout.
//  3. Contention: req0 and req1 each write continuously (0xA5A5A5A5 / 0x5A5A5A5A) for 8 transactions ->
//     SPI frames alternate 0,1,0,1...; each requester completes exactly 4.
//  4. Ordering: AW handshake 3 cycles before W, then W before AW -> single axi_awvalid and axi_wvalid pulse each; one SPI frame.
//  5. Mixed: req1 issues a read while req0 writes -> read forwarded only after req0's B handshake.
//     rdata appears on req1 slice only; req0 slice 0.
//  6. Reset mid-frame: assert RST=0 while in WR after AW handshake -> outputs 0 same cycle.
//     After release, next grant goes to requester 0 and completes normally.

Source files
------------

// File: rtl/spi_axi_arbiter.sv
// Round-robin arbiter that shares one AXI4-lite slave port (the SPI bridge) among M requesters.
// Exactly one write or read is in flight; the grant is held until its B or R handshake.
module spi_axi_arbiter #(
    parameter int M     = 2,
    parameter int sword = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [M-1:0]       req_axi_awvalid,
    output logic [M-1:0]       req_axi_awready,
    input  logic [M*sword-1:0] req_axi_awaddr,
    input  logic [M*3-1:0]     req_axi_awprot,
    input  logic [M-1:0]       req_axi_wvalid,
    output logic [M-1:0]       req_axi_wready,
    input  logic [M*sword-1:0] req_axi_wdata,
    input  logic [M*4-1:0]     req_axi_wstrb,
    output logic [M-1:0]       req_axi_bvalid,
    input  logic [M-1:0]       req_axi_bready,
    input  logic [M-1:0]       req_axi_arvalid,
    output logic [M-1:0]       req_axi_arready,
    input  logic [M*sword-1:0] req_axi_araddr,
    input  logic [M*3-1:0]     req_axi_arprot,
    output logic [M-1:0]       req_axi_rvalid,
    input  logic [M-1:0]       req_axi_rready,
    output logic [M*sword-1:0] req_axi_rdata,
    output logic               axi_awvalid,
    input  logic               axi_awready,
    output logic [sword-1:0]   axi_awaddr,
    output logic [2:0]         axi_awprot,
    output logic               axi_wvalid,
    input  logic               axi_wready,
    output logic [sword-1:0]   axi_wdata,
    output logic [3:0]         axi_wstrb,
    input  logic               axi_bvalid,
    output logic               axi_bready,
    output logic               axi_arvalid,
    input  logic               axi_arready,
    output logic [sword-1:0]   axi_araddr,
    output logic [2:0]         axi_arprot,
    input  logic               axi_rvalid,
    output logic               axi_rready,
    input  logic [sword-1:0]   axi_rdata
);
    localparam int GW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

    state_t        state_r, state_s;
    logic [GW-1:0] g_r, g_s, p_r, p_s;
    logic          aw_done_r, aw_done_s, w_done_r, w_done_s;
    logic          found_s, pick_wr_s, arb_hit_s;
    logic [GW-1:0] pick_s;
    int            arb_idx_s;
    logic          aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] idx);
        int n;
        n = (int'(idx) + 1) % M;
        return GW'(n);
    endfunction

    // Round-robin search for the first requester at or after the pointer
    always_comb begin
        found_s   = 1'b0;
        pick_s    = '0;
        pick_wr_s = 1'b0;
        arb_idx_s = 0;
        arb_hit_s = 1'b0;
        for (int k = 0; k < M; k++) begin
            arb_idx_s = (int'(p_r) + k) % M;
            arb_hit_s = ~found_s & (req_axi_awvalid[arb_idx_s] | req_axi_arvalid[arb_idx_s]);
            pick_s    = arb_hit_s ? GW'(arb_idx_s) : pick_s;
            pick_wr_s = arb_hit_s ? req_axi_awvalid[arb_idx_s] : pick_wr_s;
            found_s   = found_s | arb_hit_s;
        end
    end

    // Next-state logic and the grant-steered AXI mux
    always_comb begin
        state_s         = state_r;
        g_s             = g_r;
        p_s             = p_r;
        aw_done_s       = aw_done_r;
        w_done_s        = w_done_r;
        aw_hs_s         = 1'b0;
        w_hs_s          = 1'b0;
        b_hs_s          = 1'b0;
        ar_hs_s         = 1'b0;
        r_hs_s          = 1'b0;
        req_axi_awready = '0;
        req_axi_wready  = '0;
        req_axi_bvalid  = '0;
        req_axi_arready = '0;
        req_axi_rvalid  = '0;
        req_axi_rdata   = '0;
        axi_awvalid     = 1'b0;
        axi_awaddr      = '0;
        axi_awprot      = 3'b000;
        axi_wvalid      = 1'b0;
        axi_wdata       = '0;
        axi_wstrb       = 4'b0000;
        axi_bready      = 1'b0;
        axi_arvalid     = 1'b0;
        axi_araddr      = '0;
        axi_arprot      = 3'b000;
        axi_rready      = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s = pick_wr_s ? WR : RD;
                    g_s     = pick_s;
                end else begin
                    state_s = IDLE;
                end
            end
            WR: begin
                axi_awvalid             = req_axi_awvalid[g_r] & ~aw_done_r;
                axi_awaddr              = req_axi_awaddr[int'(g_r)*sword +: sword];
                axi_awprot              = req_axi_awprot[int'(g_r)*3 +: 3];
                axi_wvalid              = req_axi_wvalid[g_r] & ~w_done_r;
                axi_wdata               = req_axi_wdata[int'(g_r)*sword +: sword];
                axi_wstrb               = req_axi_wstrb[int'(g_r)*4 +: 4];
                axi_bready              = req_axi_bready[g_r];
                req_axi_awready[g_r]    = axi_awready & ~aw_done_r;
                req_axi_wready[g_r]     = axi_wready & ~w_done_r;
                req_axi_bvalid[g_r]     = axi_bvalid;
                aw_hs_s = req_axi_awvalid[g_r] & ~aw_done_r & axi_awready;
                w_hs_s  = req_axi_wvalid[g_r] & ~w_done_r & axi_wready;
                b_hs_s  = axi_bvalid & req_axi_bready[g_r];
                if (b_hs_s) begin
                    aw_done_s = 1'b0;
                    w_done_s  = 1'b0;
                    p_s       = next_ptr(g_r);
                    state_s   = IDLE;
                end else begin
                    aw_done_s = aw_done_r | aw_hs_s;
                    w_done_s  = w_done_r | w_hs_s;
                end
            end
            RD: begin
                // aw_done doubles as the read-address-accepted flag
                axi_arvalid             = req_axi_arvalid[g_r] & ~aw_done_r;
                axi_araddr              = req_axi_araddr[int'(g_r)*sword +: sword];
                axi_arprot              = req_axi_arprot[int'(g_r)*3 +: 3];
                axi_rready              = req_axi_rready[g_r];
                req_axi_arready[g_r]    = axi_arready & ~aw_done_r;
                req_axi_rvalid[g_r]     = axi_rvalid;
                req_axi_rdata[int'(g_r)*sword +: sword] = axi_rdata;
                ar_hs_s = req_axi_arvalid[g_r] & ~aw_done_r & axi_arready;
                r_hs_s  = axi_rvalid & req_axi_rready[g_r];
                if (r_hs_s) begin
                    aw_done_s = 1'b0;
                    p_s       = next_ptr(g_r);
                    state_s   = IDLE;
                end else begin
                    aw_done_s = aw_done_r | ar_hs_s;
                end
            end
            default: begin
                state_s   = IDLE;
                aw_done_s = 1'b0;
                w_done_s  = 1'b0;
            end
        endcase
    end

    // State, grant, round-robin pointer and handshake-done flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= IDLE;
            g_r       <= '0;
            p_r       <= '0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            g_r       <= g_s;
            p_r       <= p_s;
            aw_done_r <= aw_done_s;
            w_done_r  <= w_done_s;
        end
    end
endmodule

// File: tb/tb_spi_axi_arbiter.sv
// Directed testbench for spi_axi_arbiter with two requesters and a small AXI4-lite slave model.
module tb_spi_axi_arbiter;
    localparam int M  = 2;
    localparam int SW = 32;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    logic [M-1:0]    req_axi_awvalid, req_axi_awready, req_axi_wvalid, req_axi_wready;
    logic [M-1:0]    req_axi_bvalid, req_axi_bready, req_axi_arvalid, req_axi_arready;
    logic [M-1:0]    req_axi_rvalid, req_axi_rready;
    logic [M*SW-1:0] req_axi_awaddr, req_axi_wdata, req_axi_araddr, req_axi_rdata;
    logic [M*3-1:0]  req_axi_awprot, req_axi_arprot;
    logic [M*4-1:0]  req_axi_wstrb;

    logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic          axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [SW-1:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]    axi_awprot, axi_arprot;
    logic [3:0]    axi_wstrb;

    int tests_run    = 0;
    int tests_failed = 0;

    spi_axi_arbiter #(.M(M), .sword(SW)) dut (
        .CLK(CLK), .RST(RST),
        .req_axi_awvalid(req_axi_awvalid), .req_axi_awready(req_axi_awready),
        .req_axi_awaddr(req_axi_awaddr), .req_axi_awprot(req_axi_awprot),
        .req_axi_wvalid(req_axi_wvalid), .req_axi_wready(req_axi_wready),
        .req_axi_wdata(req_axi_wdata), .req_axi_wstrb(req_axi_wstrb),
        .req_axi_bvalid(req_axi_bvalid), .req_axi_bready(req_axi_bready),
        .req_axi_arvalid(req_axi_arvalid), .req_axi_arready(req_axi_arready),
        .req_axi_araddr(req_axi_araddr), .req_axi_arprot(req_axi_arprot),
        .req_axi_rvalid(req_axi_rvalid), .req_axi_rready(req_axi_rready),
        .req_axi_rdata(req_axi_rdata),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready), .axi_rdata(axi_rdata)
    );

    always #5 CLK = ~CLK;

    wire [110:0] slv_out = {axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata, axi_wstrb,
                            axi_bready, axi_arvalid, axi_araddr, axi_arprot, axi_rready};
    wire [73:0]  req_out = {req_axi_awready, req_axi_wready, req_axi_bvalid, req_axi_arready,
                            req_axi_rvalid, req_axi_rdata};

    // Slave model: AW/W ready gates controllable, B after both beats, R one cycle after AR
    logic s_aw_en = 1'b1;
    logic s_w_en  = 1'b1;
    logic s_aw_got, s_w_got, s_ar_got;
    assign axi_awready = s_aw_en & ~s_aw_got;
    assign axi_wready  = s_w_en & ~s_w_got;
    assign axi_arready = ~s_ar_got;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_aw_got <= 1'b0; s_w_got <= 1'b0; s_ar_got <= 1'b0;
            axi_bvalid <= 1'b0; axi_rvalid <= 1'b0; axi_rdata <= 32'h0;
        end else begin
            if (axi_awvalid && axi_awready) s_aw_got <= 1'b1;
            if (axi_wvalid && axi_wready) s_w_got <= 1'b1;
            if (s_aw_got && s_w_got && !axi_bvalid) axi_bvalid <= 1'b1;
            if (axi_bvalid && axi_bready) begin
                axi_bvalid <= 1'b0; s_aw_got <= 1'b0; s_w_got <= 1'b0;
            end
            if (axi_arvalid && axi_arready) begin
                s_ar_got <= 1'b1; axi_rvalid <= 1'b1;
                axi_rdata <= 32'hC0DE0000 | {16'h0000, axi_araddr[15:0]};
            end
            if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 1'b0; s_ar_got <= 1'b0; axi_rdata <= 32'h0;
            end
        end
    end

    // Frame log: every accepted write data beat
    logic [31:0] frames [0:255];
    int frame_cnt = 0;
    always @(posedge CLK) begin
        if (axi_wvalid && axi_wready) begin
            frames[frame_cnt & 255] <= axi_wdata;
            frame_cnt <= frame_cnt + 1;
        end
    end

    // Pulse/level counters sampled away from the clock edge
    int aw_hi_cnt = 0, aw_rise_cnt = 0, w_hi_cnt = 0, w_rise_cnt = 0, b1_cnt = 0;
    logic aw_prev = 1'b0, w_prev = 1'b0;
    always @(negedge CLK) begin
        aw_hi_cnt <= aw_hi_cnt + (axi_awvalid ? 1 : 0);
        w_hi_cnt  <= w_hi_cnt + (axi_wvalid ? 1 : 0);
        if (axi_awvalid && !aw_prev) aw_rise_cnt <= aw_rise_cnt + 1;
        if (axi_wvalid && !w_prev) w_rise_cnt <= w_rise_cnt + 1;
        if (req_axi_bvalid[1]) b1_cnt <= b1_cnt + 1;
        aw_prev <= axi_awvalid;
        w_prev  <= axi_wvalid;
    end

    task automatic clear_reqs();
        req_axi_awvalid = '0; req_axi_wvalid = '0; req_axi_bready = '0;
        req_axi_arvalid = '0; req_axi_rready = '0;
        req_axi_awaddr = '0; req_axi_wdata = '0; req_axi_araddr = '0;
        req_axi_awprot = '0; req_axi_arprot = '0; req_axi_wstrb = '0;
    endtask

    task automatic apply_reset();
        clear_reqs();
        s_aw_en = 1'b1; s_w_en = 1'b1;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic req_write(input int i, input logic [31:0] addr, input logic [31:0] data,
                             input bit hold, output bit ok);
        bit aw_pend, w_pend, aw_h, w_h, b_h;
        ok = 1'b0; aw_pend = 1'b1; w_pend = 1'b1;
        req_axi_awaddr[i*SW +: SW] = addr;
        req_axi_wdata[i*SW +: SW]  = data;
        req_axi_wstrb[i*4 +: 4]    = 4'hF;
        req_axi_awvalid[i] = 1'b1; req_axi_wvalid[i] = 1'b1; req_axi_bready[i] = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            aw_h = aw_pend & req_axi_awready[i];
            w_h  = w_pend & req_axi_wready[i];
            b_h  = req_axi_bvalid[i];
            @(posedge CLK);
            #1;
            if (aw_h) begin aw_pend = 1'b0; if (!hold) req_axi_awvalid[i] = 1'b0; end
            if (w_h) begin w_pend = 1'b0; if (!hold) req_axi_wvalid[i] = 1'b0; end
            if (b_h) begin ok = 1'b1; break; end
        end
        req_axi_awvalid[i] = 1'b0; req_axi_wvalid[i] = 1'b0; req_axi_bready[i] = 1'b0;
    endtask

    task automatic req_read(input int i, input logic [31:0] addr, output bit ok,
                            output logic [M*SW-1:0] rvec);
        bit ar_pend, ar_h, r_h;
        ok = 1'b0; ar_pend = 1'b1; rvec = '0;
        req_axi_araddr[i*SW +: SW] = addr;
        req_axi_arvalid[i] = 1'b1; req_axi_rready[i] = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            ar_h = ar_pend & req_axi_arready[i];
            r_h  = req_axi_rvalid[i];
            if (r_h) rvec = req_axi_rdata;
            @(posedge CLK);
            #1;
            if (ar_h) begin ar_pend = 1'b0; req_axi_arvalid[i] = 1'b0; end
            if (r_h) begin ok = 1'b1; break; end
        end
        req_axi_arvalid[i] = 1'b0; req_axi_rready[i] = 1'b0;
    endtask

    task automatic test_reset();
        clear_reqs();
        req_axi_awvalid = 2'b11; req_axi_wvalid = 2'b11; req_axi_arvalid = 2'b11;
        req_axi_bready = 2'b11; req_axi_rready = 2'b11; req_axi_wstrb = 8'hFF;
        req_axi_awaddr = {32'h0000_0200, 32'h0000_0100};
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        tests_run++;
        if (slv_out !== 111'd0) begin tests_failed++; $display("FAIL reset_slave_outputs: got %h want 0", slv_out); end
        tests_run++;
        if (req_out !== 74'd0) begin tests_failed++; $display("FAIL reset_req_outputs: got %h want 0", req_out); end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        tests_run++;
        if (axi_awvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_awvalid: got %b want 0", axi_awvalid); end
        @(posedge CLK);
        #1;
        tests_run++;
        if (axi_awvalid !== 1'b1) begin tests_failed++; $display("FAIL reset_first_awvalid: got %b want 1", axi_awvalid); end
        tests_run++;
        if (axi_awaddr !== 32'h0000_0100) begin tests_failed++; $display("FAIL reset_grant_addr: got %h want 00000100", axi_awaddr); end
        tests_run++;
        if (req_axi_awready !== 2'b01) begin tests_failed++; $display("FAIL reset_grant_awready: got %b want 01", req_axi_awready); end
        tests_run++;
        if (req_axi_arready !== 2'b00) begin tests_failed++; $display("FAIL reset_grant_arready: got %b want 00", req_axi_arready); end
    endtask

    task automatic test_single_write();
        bit ok;
        int base, b1_base;
        apply_reset();
        base = frame_cnt; b1_base = b1_cnt;
        req_write(0, 32'h0000_0010, 32'hDEADBEEF, 1'b0, ok);
        @(negedge CLK);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL single_write_done: got %b want 1", ok); end
        tests_run++;
        if (frame_cnt - base !== 1) begin tests_failed++; $display("FAIL single_write_frames: got %0d want 1", frame_cnt - base); end
        tests_run++;
        if (frames[base & 255] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL single_write_data: got %h want deadbeef", frames[base & 255]); end
        tests_run++;
        if (b1_cnt - b1_base !== 0) begin tests_failed++; $display("FAIL single_write_bvalid1: got %0d cycles want 0", b1_cnt - b1_base); end
    endtask

    task automatic test_contention();
        int base, ok0, ok1;
        logic [31:0] exp_d;
        apply_reset();
        base = frame_cnt; ok0 = 0; ok1 = 0;
        fork
            begin
                bit oka;
                for (int n = 0; n < 4; n++) begin
                    req_write(0, 32'h0000_0040, 32'hA5A5A5A5, 1'b0, oka);
                    ok0 += int'(oka);
                end
            end
            begin
                bit okb;
                for (int n = 0; n < 4; n++) begin
                    req_write(1, 32'h0000_0080, 32'h5A5A5A5A, 1'b0, okb);
                    ok1 += int'(okb);
                end
            end
        join
        @(negedge CLK);
        tests_run++;
        if (ok0 !== 4) begin tests_failed++; $display("FAIL contention_req0_count: got %0d want 4", ok0); end
        tests_run++;
        if (ok1 !== 4) begin tests_failed++; $display("FAIL contention_req1_count: got %0d want 4", ok1); end
        tests_run++;
        if (frame_cnt - base !== 8) begin tests_failed++; $display("FAIL contention_frames: got %0d want 8", frame_cnt - base); end
        for (int j = 0; j < 8; j++) begin
            exp_d = (j % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
            tests_run++;
            if (frames[(base + j) & 255] !== exp_d) begin
                tests_failed++;
                $display("FAIL contention_order[%0d]: got %h want %h", j, frames[(base + j) & 255], exp_d);
            end
        end
    endtask

    task automatic test_ordering();
        bit ok;
        int base, awh, wr, wh, awr;
        // AW accepted first, W three cycles later; requester holds both valids until B
        apply_reset();
        base = frame_cnt; awh = aw_hi_cnt; wr = w_rise_cnt;
        s_w_en = 1'b0;
        fork
            req_write(0, 32'h0000_0020, 32'h1234_5678, 1'b1, ok);
            begin
                for (int c = 0; c < 50; c++) begin @(negedge CLK); if (s_aw_got) break; end
                repeat (3) @(posedge CLK);
                #1 s_w_en = 1'b1;
            end
        join
        @(negedge CLK);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL order_aw_first_done: got %b want 1", ok); end
        tests_run++;
        if (aw_hi_cnt - awh !== 1) begin tests_failed++; $display("FAIL order_aw_first_awvalid_cycles: got %0d want 1", aw_hi_cnt - awh); end
        tests_run++;
        if (w_rise_cnt - wr !== 1) begin tests_failed++; $display("FAIL order_aw_first_wvalid_pulses: got %0d want 1", w_rise_cnt - wr); end
        tests_run++;
        if (frame_cnt - base !== 1) begin tests_failed++; $display("FAIL order_aw_first_frames: got %0d want 1", frame_cnt - base); end
        // W accepted first, AW three cycles later
        apply_reset();
        base = frame_cnt; wh = w_hi_cnt; awr = aw_rise_cnt;
        s_aw_en = 1'b0;
        fork
            req_write(0, 32'h0000_0024, 32'h8765_4321, 1'b1, ok);
            begin
                for (int c = 0; c < 50; c++) begin @(negedge CLK); if (s_w_got) break; end
                repeat (3) @(posedge CLK);
                #1 s_aw_en = 1'b1;
            end
        join
        @(negedge CLK);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL order_w_first_done: got %b want 1", ok); end
        tests_run++;
        if (w_hi_cnt - wh !== 1) begin tests_failed++; $display("FAIL order_w_first_wvalid_cycles: got %0d want 1", w_hi_cnt - wh); end
        tests_run++;
        if (aw_rise_cnt - awr !== 1) begin tests_failed++; $display("FAIL order_w_first_awvalid_pulses: got %0d want 1", aw_rise_cnt - awr); end
        tests_run++;
        if (frame_cnt - base !== 1) begin tests_failed++; $display("FAIL order_w_first_frames: got %0d want 1", frame_cnt - base); end
    endtask

    task automatic test_mixed();
        bit okw, okr;
        logic [M*SW-1:0] rvec;
        int viol;
        apply_reset();
        viol = 0;
        fork
            req_write(0, 32'h0000_0030, 32'hCAFEF00D, 1'b0, okw);
            req_read(1, 32'h0000_1234, okr, rvec);
            begin
                bit bdone;
                bdone = 1'b0;
                repeat (40) begin
                    @(negedge CLK);
                    if (axi_arvalid && !bdone) viol++;
                    if (axi_bvalid && axi_bready) bdone = 1'b1;
                end
            end
        join
        tests_run++;
        if (okw !== 1'b1) begin tests_failed++; $display("FAIL mixed_write_done: got %b want 1", okw); end
        tests_run++;
        if (okr !== 1'b1) begin tests_failed++; $display("FAIL mixed_read_done: got %b want 1", okr); end
        tests_run++;
        if (viol !== 0) begin tests_failed++; $display("FAIL mixed_read_before_b: got %0d early cycles want 0", viol); end
        tests_run++;
        if (rvec[63:32] !== 32'hC0DE1234) begin tests_failed++; $display("FAIL mixed_rdata_req1: got %h want c0de1234", rvec[63:32]); end
        tests_run++;
        if (rvec[31:0] !== 32'h0) begin tests_failed++; $display("FAIL mixed_rdata_req0: got %h want 0", rvec[31:0]); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok, ok0, ok1;
        int base;
        apply_reset();
        req_write(0, 32'h0000_0300, 32'h1111_2222, 1'b0, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL midreset_pre_write: got %b want 1", ok); end
        s_w_en = 1'b0;
        req_axi_awaddr[SW +: SW] = 32'h0000_0400;
        req_axi_wdata[SW +: SW]  = 32'h3333_4444;
        req_axi_wstrb[7:4] = 4'hF;
        req_axi_awvalid[1] = 1'b1; req_axi_wvalid[1] = 1'b1; req_axi_bready[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin @(negedge CLK); if (s_aw_got) break; end
        tests_run++;
        if (axi_wvalid !== 1'b1) begin tests_failed++; $display("FAIL midreset_pre_wvalid: got %b want 1", axi_wvalid); end
        RST = 1'b0;
        #1;
        tests_run++;
        if (slv_out !== 111'd0) begin tests_failed++; $display("FAIL midreset_slave_outputs: got %h want 0", slv_out); end
        tests_run++;
        if (req_out !== 74'd0) begin tests_failed++; $display("FAIL midreset_req_outputs: got %h want 0", req_out); end
        clear_reqs();
        s_w_en = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        base = frame_cnt;
        fork
            req_write(0, 32'h0000_0500, 32'h5555_6666, 1'b0, ok0);
            req_write(1, 32'h0000_0600, 32'h7777_8888, 1'b0, ok1);
        join
        @(negedge CLK);
        tests_run++;
        if ({ok0, ok1} !== 2'b11) begin tests_failed++; $display("FAIL midreset_post_done: got %b%b want 11", ok0, ok1); end
        tests_run++;
        if (frames[base & 255] !== 32'h5555_6666) begin tests_failed++; $display("FAIL midreset_first_grant: got %h want 55556666", frames[base & 255]); end
        tests_run++;
        if (frames[(base + 1) & 255] !== 32'h7777_8888) begin tests_failed++; $display("FAIL midreset_second_grant: got %h want 77778888", frames[(base + 1) & 255]); end
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_single_write();
        test_contention();
        test_ordering();
        test_mixed();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
